// File: rtl/modn_counter_cfg.sv
// modn_counter_cfg: mod-N counter with a modulus that can be changed at runtime.
// Supports enable, up/down direction, synchronous load, and wrap or saturate mode.
// Emits a registered terminal-count pulse (tc) so instances can cascade.
// Optional feature macro MODN_WRAPCNT_EN adds a saturating 16-bit wrap counter
// output (wrap_cnt). This counter clears on load.
module modn_counter_cfg #(
  parameter int WIDTH   = 8,
  parameter int MOD_RST = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             up,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             cfg_we,
  input  logic [WIDTH:0]   cfg_mod,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH:0]   mod_cur,
  output logic             tc,
  output logic             cfg_err
`ifdef MODN_WRAPCNT_EN
  ,
  output logic [15:0]      wrap_cnt
`endif
);

  // Modulus bounds and constants, all held in WIDTH+1 bits so that a modulus
  // of 2**WIDTH is representable.
  localparam logic [WIDTH:0]   MOD_RST_V = (WIDTH+1)'(MOD_RST);
  localparam logic [WIDTH:0]   MIN_MOD   = {{(WIDTH-1){1'b0}}, 2'b10};
  localparam logic [WIDTH:0]   MAX_MOD   = {1'b1, {WIDTH{1'b0}}};
  localparam logic [WIDTH:0]   ONE_X     = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ONE_Q     = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH:0] q_ext;
  logic [WIDTH:0] mod_m1;
  logic [WIDTH:0] term;
  logic           at_term;
  logic           cfg_ok;
  logic           load_ok;
  logic           wrap_evt;

  assign q_ext    = {1'b0, q};
  assign mod_m1   = mod_cur - ONE_X;
  // The terminal value depends on direction, so changing up re-targets it.
  assign term     = up ? mod_m1 : '0;
  assign at_term  = (q_ext == term);
  assign cfg_ok   = (cfg_mod >= MIN_MOD) && (cfg_mod <= MAX_MOD);
  assign load_ok  = ({1'b0, load_val} < mod_cur);
  // A wrap-mode terminal step only happens when neither cfg_we nor load wins priority.
  assign wrap_evt = !cfg_we && !load && en && at_term && !sat;

  // Counter, modulus and pulse state. Priority order: cfg_we, then load, then en, then hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q       <= '0;
      mod_cur <= MOD_RST_V;
      tc      <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults first; a later assignment in the same
      // block overrides them, which makes tc and cfg_err one-cycle pulses.
      tc      <= 1'b0;
      cfg_err <= 1'b0;
      if (cfg_we) begin
        if (cfg_ok) begin
          mod_cur <= cfg_mod;
          if (q_ext >= cfg_mod) q <= '0;
        end else begin
          cfg_err <= 1'b1;
        end
      end else if (load) begin
        q <= load_ok ? load_val : mod_m1[WIDTH-1:0];
      end else if (en) begin
        if (at_term) begin
          tc <= 1'b1;
          if (!sat) q <= up ? '0 : mod_m1[WIDTH-1:0];
        end else begin
          q <= up ? q + ONE_Q : q - ONE_Q;
        end
      end
    end
  end

`ifdef MODN_WRAPCNT_EN
  // Count wrap-mode terminal events, saturating at all-ones; a load that takes effect clears the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrap_cnt <= '0;
    end else if (load && !cfg_we) begin
      wrap_cnt <= '0;
    end else if (wrap_evt && (wrap_cnt != 16'hFFFF)) begin
      wrap_cnt <= wrap_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_modn_counter_cfg.sv
// Testbench for modn_counter_cfg (WIDTH=8, MOD_RST=8).
// The vector table exercises counting, load, modulus changes and saturation.
// Hand-written sequences cover the asynchronous reset and, when
// MODN_WRAPCNT_EN is defined, the wrap counter.
module tb_modn_counter_cfg;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       en = 1'b0, up = 1'b0, sat = 1'b0, load = 1'b0, cfg_we = 1'b0;
  logic [7:0] load_val = '0;
  logic [8:0] cfg_mod = '0;
  logic [7:0] q;
  logic [8:0] mod_cur;
  logic       tc, cfg_err;
`ifdef MODN_WRAPCNT_EN
  logic [15:0] wrap_cnt;
`endif

  int tests = 0;
  int fails = 0;

  modn_counter_cfg #(.WIDTH(8), .MOD_RST(8)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (en),
    .up       (up),
    .sat      (sat),
    .load     (load),
    .load_val (load_val),
    .cfg_we   (cfg_we),
    .cfg_mod  (cfg_mod),
    .q        (q),
    .mod_cur  (mod_cur),
    .tc       (tc),
    .cfg_err  (cfg_err)
`ifdef MODN_WRAPCNT_EN
    ,
    .wrap_cnt (wrap_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en, up, sat, ld;
    logic [7:0] lv;
    logic       we;
    logic [8:0] cm;
    logic [7:0] eq;
    logic [8:0] em;
    logic       etc, eerr;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic e, input logic u, input logic s, input logic l,
                     input logic [7:0] lv, input logic w, input logic [8:0] cm,
                     input logic [7:0] eq, input logic [8:0] em,
                     input logic etc, input logic eerr);
    vec_t v;
    v.en = e; v.up = u; v.sat = s; v.ld = l; v.lv = lv; v.we = w; v.cm = cm;
    v.eq = eq; v.em = em; v.etc = etc; v.eerr = eerr;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic e, input logic u, input logic s, input logic l,
                       input logic [7:0] lv, input logic w, input logic [8:0] cm);
    en = e; up = u; sat = s; load = l; load_val = lv; cfg_we = w; cfg_mod = cm;
  endtask

  // Outputs are sampled 1 time unit after the rising edge, while the inputs are stable.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Columns: en up sat load load_val cfg_we cfg_mod | q mod_cur tc cfg_err
    // Up count in wrap mode with modulus 8: 1..7, then the wrap 7->0 with tc.
    for (int i = 1; i <= 7; i++) add(1,1,0,0,0,0,0, 8'(i), 8, 0, 0);
    add(1,1,0,0,0,0,0,   0,   8, 1, 0);
    add(1,1,0,0,0,0,0,   1,   8, 0, 0);
    // Down count in saturate mode with modulus 5, starting from a load of 2.
    add(0,0,0,0,0,1,5,   1,   5, 0, 0);
    add(1,0,1,1,2,0,0,   2,   5, 0, 0);
    add(1,0,1,0,0,0,0,   1,   5, 0, 0);
    add(1,0,1,0,0,0,0,   0,   5, 0, 0);
    add(1,0,1,0,0,0,0,   0,   5, 1, 0);
    add(1,0,1,0,0,0,0,   0,   5, 1, 0);
    add(0,0,0,0,0,0,0,   0,   5, 0, 0);
    // Load clamp: 200 is clamped to 9 and the load wins over en; next up step wraps.
    add(0,0,0,0,0,1,10,  0,  10, 0, 0);
    add(1,1,0,1,200,0,0, 9,  10, 0, 0);
    add(1,1,0,0,0,0,0,   0,  10, 1, 0);
    // Shrink the modulus, then attempt rejected writes of 1 and 257.
    add(0,0,0,1,7,0,0,   7,  10, 0, 0);
    add(0,0,0,0,0,1,4,   0,   4, 0, 0);
    add(0,0,0,0,0,1,1,   0,   4, 0, 1);
    add(0,0,0,0,0,0,0,   0,   4, 0, 0);
    add(0,0,0,0,0,1,257, 0,   4, 0, 1);
    add(0,0,0,0,0,0,0,   0,   4, 0, 0);
    // New modulus equal to q forces q to 0; then a down wrap 0->2 in wrap mode.
    add(0,0,0,1,3,0,0,   3,   4, 0, 0);
    add(0,0,0,0,0,1,3,   0,   3, 0, 0);
    add(1,0,0,0,0,0,0,   2,   3, 1, 0);
    add(1,0,0,0,0,0,0,   1,   3, 0, 0);
    // Full range with modulus 256: 254,255, then the wrap to 0.
    add(0,0,0,0,0,1,256, 1, 256, 0, 0);
    add(0,0,0,1,254,0,0, 254,256,0, 0);
    add(1,1,0,0,0,0,0, 255, 256, 0, 0);
    add(1,1,0,0,0,0,0,   0, 256, 1, 0);
    add(1,1,0,0,0,0,0,   1, 256, 0, 0);
    // A direction change re-targets T; down from 0 wraps to 255.
    add(1,0,0,0,0,0,0,   0, 256, 0, 0);
    add(1,0,0,0,0,0,0, 255, 256, 1, 0);
    // cfg_we beats load and en: the rejected write leaves q alone and gives no tc.
    add(1,1,0,1,5,1,1, 255, 256, 0, 1);
    // load_val = mod_cur-1 is in range, so it loads without clamping.
    add(0,0,0,1,255,0,0,255,256, 0, 0);

    // State while reset is held low.
    tick();
    check("reset q", 32'(q), 0);
    check("reset mod_cur", 32'(mod_cur), 8);
    check("reset tc", 32'(tc), 0);
    check("reset cfg_err", 32'(cfg_err), 0);
    tick();
    check("reset held q", 32'(q), 0);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].en, vecs[i].up, vecs[i].sat, vecs[i].ld, vecs[i].lv, vecs[i].we, vecs[i].cm);
      tick();
      check($sformatf("vec%0d q", i), 32'(q), 32'(vecs[i].eq));
      check($sformatf("vec%0d mod_cur", i), 32'(mod_cur), 32'(vecs[i].em));
      check($sformatf("vec%0d tc", i), 32'(tc), 32'(vecs[i].etc));
      check($sformatf("vec%0d cfg_err", i), 32'(cfg_err), 32'(vecs[i].eerr));
    end

    // Async reset mid-operation: q=5 and a pending cfg_err are both cleared before the next edge.
    drive(0,0,0,1,5,0,0);
    tick();
    check("pre-reset q", 32'(q), 5);
    drive(0,0,0,0,0,1,0);
    tick();
    check("pre-reset cfg_err", 32'(cfg_err), 1);
    drive(0,0,0,0,0,0,0);
    #2 reset_n = 1'b0;
    #1;
    check("async reset q", 32'(q), 0);
    check("async reset mod_cur", 32'(mod_cur), 8);
    check("async reset tc", 32'(tc), 0);
    check("async reset cfg_err", 32'(cfg_err), 0);
    tick();
    reset_n = 1'b1;

`ifdef MODN_WRAPCNT_EN
    // Three wraps with modulus 8 take 24 enabled up steps; a load then clears the count.
    check("wrap_cnt reset", 32'(wrap_cnt), 0);
    drive(1,1,0,0,0,0,0);
    repeat (24) tick();
    check("wrap_cnt after 3 wraps", 32'(wrap_cnt), 3);
    check("q after 3 wraps", 32'(q), 0);
    drive(0,0,0,1,3,0,0);
    tick();
    check("wrap_cnt cleared by load", 32'(wrap_cnt), 0);
    check("q after load", 32'(q), 3);
    drive(0,0,0,0,0,0,0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
